// File: rtl/scan_mux_n_if.sv
// Channel bus for scan_mux_n: source data, mode/select/mask/advance in,
// registered OUT/CH/VALID/WRAP back. master = stimulus side, slave = mux.
interface scan_mux_n_if #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic [NCH*WIDTH-1:0] D;
  logic                 MODE;
  logic [SELW-1:0]      SEL;
  logic [NCH-1:0]       EN_MASK;
  logic                 ADV;
  logic [WIDTH-1:0]     OUT;
  logic [SELW-1:0]      CH;
  logic                 VALID;
  logic                 WRAP;

  modport master (
    output D, MODE, SEL, EN_MASK, ADV,
    input  OUT, CH, VALID, WRAP
  );

  modport slave (
    input  D, MODE, SEL, EN_MASK, ADV,
    output OUT, CH, VALID, WRAP
  );
endinterface

// File: rtl/scan_mux_n.sv
// Clocked N:1 channel mux, manual select or masked round-robin auto-scan.
// Ports: CLK, RST (sync, active-high), bus (scan_mux_n_if.slave).
module scan_mux_n #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input logic         CLK,
  input logic         RST,
  scan_mux_n_if.slave bus
);

  typedef enum logic [1:0] {
    S_MANUAL,
    S_SCAN,
    S_STALL
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [SELW-1:0]  r_ch;
  logic             r_valid;
  logic             r_wrap;

  // First enabled index at or after start, modulo NCH.
  // Out-of-range starts search from 0.
  function automatic logic [SELW-1:0] first_from(
    input logic [SELW-1:0] start,
    input logic [NCH-1:0]  mask
  );
    int   s;
    int   idx;
    logic found;
    first_from = start;
    found      = 1'b0;
    s = (int'(start) < NCH) ? int'(start) : 0;
    for (int i = 0; i < NCH; i++) begin
      idx = s + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && mask[idx]) begin
        found      = 1'b1;
        first_from = SELW'(idx);
      end
    end
  endfunction

  function automatic logic [WIDTH-1:0] pick(
    input logic [NCH*WIDTH-1:0] d,
    input logic [SELW-1:0]      k
  );
    pick = '0;
    for (int i = 0; i < NCH; i++)
      if (int'(k) == i) pick = d[i*WIDTH +: WIDTH];
  endfunction

  logic            w_sel_ok;
  logic            w_mask_zero;
  logic [SELW-1:0] w_start;
  logic [SELW-1:0] w_entry;
  logic [SELW-1:0] w_after;
  logic [SELW-1:0] w_step;
  logic            w_cur_en;
  logic            w_move;

  assign w_sel_ok    = int'(bus.SEL) < NCH;
  assign w_mask_zero = (bus.EN_MASK == '0);

  // Entry from MANUAL starts at SEL; re-entry from STALL at the held CH.
  assign w_start = (r_state == S_MANUAL) ? bus.SEL : r_ch;
  assign w_entry = first_from(w_start, bus.EN_MASK);

  // Successor search is modulo NCH, not 2^SELW.
  assign w_after = (int'(r_ch) + 1 >= NCH) ? '0 : r_ch + 1'b1;
  assign w_step  = first_from(w_after, bus.EN_MASK);

  always_comb begin
    w_cur_en = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (int'(r_ch) == i) w_cur_en = bus.EN_MASK[i];
  end

  // A disabled current channel steps away as if advanced.
  assign w_move = bus.ADV || !w_cur_en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_MANUAL;
      r_out   <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (!bus.MODE) begin
        r_state <= S_MANUAL;
        r_ch    <= bus.SEL;
        r_valid <= w_sel_ok;
        r_out   <= pick(bus.D, bus.SEL);
      end else begin
        unique case (r_state)
          S_MANUAL, S_STALL: begin
            if (w_mask_zero) begin
              r_state <= S_STALL;
              r_ch    <= w_start;
              r_out   <= '0;
              r_valid <= 1'b0;
            end else begin
              r_state <= S_SCAN;
              r_ch    <= w_entry;
              r_out   <= pick(bus.D, w_entry);
              r_valid <= 1'b1;
            end
          end
          S_SCAN: begin
            if (w_mask_zero) begin
              r_state <= S_STALL;
              r_out   <= '0;
              r_valid <= 1'b0;
            end else if (w_move) begin
              r_ch    <= w_step;
              r_out   <= pick(bus.D, w_step);
              r_valid <= 1'b1;
              r_wrap  <= (w_step <= r_ch);
            end else begin
              r_out   <= pick(bus.D, r_ch);
              r_valid <= 1'b1;
            end
          end
          default: begin
            r_state <= S_MANUAL;
            r_out   <= '0;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.OUT   = r_out;
  assign bus.CH    = r_ch;
  assign bus.VALID = r_valid;
  assign bus.WRAP  = r_wrap;

endmodule

// File: tb/tb_scan_mux_n.sv
// Self-checking bench for scan_mux_n: NCH=4 unit against a rule-level
// model plus directed NCH=5 checks of out-of-range select and wrap.
module tb_scan_mux_n;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scan_mux_n_if #(.WIDTH(8), .NCH(4), .SELW(2)) b4 ();
  scan_mux_n_if #(.WIDTH(8), .NCH(5), .SELW(3)) b5 ();

  scan_mux_n #(.WIDTH(8), .NCH(4), .SELW(2)) dut4 (
    .CLK(clk), .RST(rst), .bus(b4)
  );
  scan_mux_n #(.WIDTH(8), .NCH(5), .SELW(3)) dut5 (
    .CLK(clk), .RST(rst), .bus(b5)
  );

  // Model of the NCH=4 unit: mode 0 manual, 1 scanning, 2 stalled.
  int         m_st;
  logic [7:0] m_out;
  logic [1:0] m_ch;
  logic       m_valid;
  logic       m_wrap;

  function automatic int nxt(int start, logic [3:0] m);
    for (int i = 0; i < 4; i++)
      if (m[(start + i) % 4]) return (start + i) % 4;
    return start;
  endfunction

  function automatic logic [7:0] dat(int k);
    return b4.D[8*k +: 8];
  endfunction

  function automatic void model_edge();
    int c;
    int n;
    if (rst) begin
      m_st = 0; m_out = 0; m_ch = 0; m_valid = 0; m_wrap = 0;
      return;
    end
    m_wrap = 0;
    c = int'(m_ch);
    if (!b4.MODE) begin
      m_st = 0;
      m_ch = b4.SEL;
      m_out = dat(int'(b4.SEL));
      m_valid = 1;
    end else if (m_st != 1) begin
      if (m_st == 0) c = int'(b4.SEL);
      if (b4.EN_MASK == 0) begin
        m_st = 2; m_ch = 2'(c); m_out = 0; m_valid = 0;
      end else begin
        m_st = 1;
        n = nxt(c, b4.EN_MASK);
        m_ch = 2'(n); m_out = dat(n); m_valid = 1;
      end
    end else begin
      if (b4.EN_MASK == 0) begin
        m_st = 2; m_out = 0; m_valid = 0;
      end else begin
        if (b4.ADV || !b4.EN_MASK[c]) begin
          n = nxt(c + 1, b4.EN_MASK);
          m_wrap = (n <= c);
          c = n;
        end
        m_ch = 2'(c); m_out = dat(c); m_valid = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.MODE = 1'b1; b4.SEL = 2'd2; b4.EN_MASK = 4'hF; b4.ADV = 1'b1;
    b4.D = 32'hFFFF_FFFF;
    b5.MODE = 1'b1; b5.SEL = 3'd3; b5.EN_MASK = 5'h1F; b5.ADV = 1'b1;
    b5.D = '1;
    tick();
    tick();
    checks++;
    if ({b4.OUT, b4.CH, b4.VALID, b4.WRAP} !== 12'h0) begin
      errors++;
      $display("FAIL reset4 got out=%h ch=%0d v=%b w=%b want all 0",
               b4.OUT, b4.CH, b4.VALID, b4.WRAP);
    end
    checks++;
    if ({b5.OUT, b5.CH, b5.VALID, b5.WRAP} !== 13'h0) begin
      errors++;
      $display("FAIL reset5 got out=%h ch=%0d v=%b w=%b want all 0",
               b5.OUT, b5.CH, b5.VALID, b5.WRAP);
    end
    rst = 1'b0;
    b4.MODE = 1'b0; b4.ADV = 1'b0;
    b5.MODE = 1'b0; b5.ADV = 1'b0;
  endtask

  task automatic test_manual_sweep();
    logic [7:0] exp_out [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    b4.D = 32'hD3C2_B1A0;
    b4.MODE = 1'b0;
    for (int s = 0; s < 4; s++) begin
      b4.SEL = 2'(s);
      tick();
      checks++;
      if (b4.OUT !== exp_out[s] || b4.CH !== 2'(s) ||
          b4.VALID !== 1'b1 || b4.WRAP !== 1'b0) begin
        errors++;
        $display("FAIL manual sel=%0d got out=%h ch=%0d v=%b w=%b want %h %0d 1 0",
                 s, b4.OUT, b4.CH, b4.VALID, b4.WRAP, exp_out[s], s);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    b4.MODE = 1'b0; tick();
    b4.MODE = 1'b1; b4.SEL = 2'd2; b4.EN_MASK = 4'hF; b4.ADV = 1'b0;
    tick();
    checks++;
    if (b4.CH !== 2'd2 || b4.VALID !== 1'b1) begin
      errors++;
      $display("FAIL scan_entry got ch=%0d v=%b want 2 1", b4.CH, b4.VALID);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({b4.OUT, b4.CH, b4.VALID, b4.WRAP} !== 12'h0) begin
      errors++;
      $display("FAIL rst_mid got out=%h ch=%0d v=%b w=%b want all 0",
               b4.OUT, b4.CH, b4.VALID, b4.WRAP);
    end
    b4.SEL = 2'd1; tick();
    checks++;
    if (b4.CH !== 2'd1 || b4.VALID !== 1'b1 || b4.OUT !== b4.D[15:8]) begin
      errors++;
      $display("FAIL rst_reenter got ch=%0d v=%b out=%h want 1 1 %h",
               b4.CH, b4.VALID, b4.OUT, b4.D[15:8]);
    end
  endtask

  task automatic test_masked_rr();
    int         exp_ch [6] = '{0, 1, 3, 0, 1, 3};
    logic       exp_w  [6] = '{0, 0, 0, 1, 0, 0};
    logic [7:0] want;
    b4.MODE = 1'b0; tick();
    b4.MODE = 1'b1; b4.SEL = 2'd0; b4.EN_MASK = 4'b1011; b4.ADV = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b4.D = $urandom;
      tick();
      want = b4.D[8*exp_ch[i] +: 8];
      checks++;
      if (b4.CH !== 2'(exp_ch[i]) || b4.WRAP !== exp_w[i] ||
          b4.OUT !== want || b4.VALID !== 1'b1) begin
        errors++;
        $display("FAIL rr step=%0d got ch=%0d w=%b out=%h want %0d %b %h",
                 i, b4.CH, b4.WRAP, b4.OUT, exp_ch[i], exp_w[i], want);
      end
    end
    b4.ADV = 1'b0;
  endtask

  task automatic test_disable_current();
    b4.MODE = 1'b0; tick();
    b4.MODE = 1'b1; b4.SEL = 2'd1; b4.EN_MASK = 4'b1011; b4.ADV = 1'b0;
    tick();
    b4.EN_MASK = 4'b1001; tick();
    checks++;
    if (b4.CH !== 2'd3 || b4.WRAP !== 1'b0 || b4.VALID !== 1'b1) begin
      errors++;
      $display("FAIL disable got ch=%0d w=%b v=%b want 3 0 1",
               b4.CH, b4.WRAP, b4.VALID);
    end
    b4.EN_MASK = 4'b0000; tick();
    checks++;
    if (b4.CH !== 2'd3 || b4.VALID !== 1'b0 || b4.OUT !== 8'h00) begin
      errors++;
      $display("FAIL stall got ch=%0d v=%b out=%h want 3 0 00",
               b4.CH, b4.VALID, b4.OUT);
    end
    b4.ADV = 1'b1; tick(); b4.ADV = 1'b0;
    checks++;
    if (b4.CH !== 2'd3 || b4.VALID !== 1'b0 || b4.WRAP !== 1'b0) begin
      errors++;
      $display("FAIL stall_adv got ch=%0d v=%b w=%b want 3 0 0",
               b4.CH, b4.VALID, b4.WRAP);
    end
    b4.EN_MASK = 4'b0001; tick();
    checks++;
    if (b4.CH !== 2'd0 || b4.VALID !== 1'b1 || b4.OUT !== b4.D[7:0]) begin
      errors++;
      $display("FAIL unstall got ch=%0d v=%b out=%h want 0 1 %h",
               b4.CH, b4.VALID, b4.OUT, b4.D[7:0]);
    end
  endtask

  task automatic test_single_priority();
    b4.MODE = 1'b0; tick();
    b4.MODE = 1'b1; b4.SEL = 2'd2; b4.EN_MASK = 4'b0100; b4.ADV = 1'b0;
    tick();
    b4.ADV = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b4.CH !== 2'd2 || b4.WRAP !== 1'b1) begin
        errors++;
        $display("FAIL single i=%0d got ch=%0d w=%b want 2 1",
                 i, b4.CH, b4.WRAP);
      end
    end
    b4.MODE = 1'b0; b4.SEL = 2'd1; tick();
    checks++;
    if (b4.CH !== 2'd1 || b4.WRAP !== 1'b0 || b4.OUT !== b4.D[15:8]) begin
      errors++;
      $display("FAIL mode_prio got ch=%0d w=%b out=%h want 1 0 %h",
               b4.CH, b4.WRAP, b4.OUT, b4.D[15:8]);
    end
    b4.ADV = 1'b0;
  endtask

  task automatic test_nch5();
    b5.D = {$urandom, $urandom};
    b5.MODE = 1'b0; b5.SEL = 3'd6; b5.ADV = 1'b0; b5.EN_MASK = 5'b00101;
    tick();
    checks++;
    if (b5.OUT !== 8'h00 || b5.VALID !== 1'b0 || b5.CH !== 3'd6) begin
      errors++;
      $display("FAIL n5_oor got out=%h v=%b ch=%0d want 00 0 6",
               b5.OUT, b5.VALID, b5.CH);
    end
    b5.MODE = 1'b1; tick();
    checks++;
    if (b5.CH !== 3'd0 || b5.VALID !== 1'b1 || b5.OUT !== b5.D[7:0]) begin
      errors++;
      $display("FAIL n5_entry got ch=%0d v=%b out=%h want 0 1 %h",
               b5.CH, b5.VALID, b5.OUT, b5.D[7:0]);
    end
    b5.ADV = 1'b1; tick();
    checks++;
    if (b5.CH !== 3'd2 || b5.WRAP !== 1'b0 || b5.OUT !== b5.D[23:16]) begin
      errors++;
      $display("FAIL n5_adv got ch=%0d w=%b out=%h want 2 0 %h",
               b5.CH, b5.WRAP, b5.OUT, b5.D[23:16]);
    end
    tick();
    checks++;
    if (b5.CH !== 3'd0 || b5.WRAP !== 1'b1) begin
      errors++;
      $display("FAIL n5_wrap got ch=%0d w=%b want 0 1", b5.CH, b5.WRAP);
    end
    b5.ADV = 1'b0; b5.MODE = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      b4.D = $urandom;
      b4.MODE = ($urandom_range(0, 3) != 0);
      b4.SEL = 2'($urandom_range(0, 3));
      b4.ADV = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        b4.EN_MASK = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if ({b4.OUT, b4.CH, b4.VALID, b4.WRAP} !==
          {m_out, m_ch, m_valid, m_wrap}) begin
        errors++;
        $display("FAIL random i=%0d got out=%h ch=%0d v=%b w=%b want %h %0d %b %b",
                 i, b4.OUT, b4.CH, b4.VALID, b4.WRAP,
                 m_out, m_ch, m_valid, m_wrap);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual_sweep();
    test_reset_mid_scan();
    test_masked_rr();
    test_disable_current();
    test_single_priority();
    test_nch5();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
